// File: rtl/fetch_aligner_pkg.sv
// -----------------------------------------------------------------------------
// fetch_aligner_pkg
// Shared RV32 opcode constants, the instruction-length predicate and small
// encoder helpers used to build 32-bit instructions from compressed fields.
// Imported by comp_decoder and fetch_aligner.
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_aligner_pkg;

   // Major opcodes of the RV32I base instructions that RVC expands into.
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_OP_IMM = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_OP     = 7'h33;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   // Low two bits that mark a full-length (32-bit) instruction.
   localparam logic [1:0] LEN32_MARK = 2'b11;

   // Classification of what the aligner can do with its buffered halves.
   typedef enum logic [2:0] {
      STEP_NONE,
      STEP_CARRY_EMIT,
      STEP_HALF,
      STEP_FULL,
      STEP_CARRY_LOAD
   } step_e;

   // An instruction is 16 bits wide unless its low two bits are 2'b11.
   function automatic logic is_compressed(input logic [1:0] low_bits);
      return low_bits != LEN32_MARK;
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
   endfunction

   // Branch offsets are always even, so only bits [12:1] are carried.
   function automatic logic [31:0] enc_b(input logic [12:1] off, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OP_BRANCH};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:1] off, input logic [4:0] rd);
      return {off[20], off[10:1], off[11], off[19:12], rd, OP_JAL};
   endfunction

endpackage

// File: rtl/comp_decoder.sv
// -----------------------------------------------------------------------------
// comp_decoder
// Purely combinational RV32C expander. A 16-bit instruction in ins_in[15:0]
// is rewritten into its 32-bit RV32I equivalent; a 32-bit instruction passes
// through untouched.
// Ports:
//   ins_in      in  32  candidate instruction (compressed ones in [15:0])
//   ins_out     out 32  expanded instruction (0 when illegal)
//   illegal_ins out 1   encoding is reserved or not valid for RV32IC
// -----------------------------------------------------------------------------
module comp_decoder (
   input  logic [31:0] ins_in,
   output logic [31:0] ins_out,
   output logic        illegal_ins
);
   import fetch_aligner_pkg::*;

   logic [15:0] c;
   logic [4:0]  rd;
   logic [4:0]  rs2;
   logic [4:0]  rdp;
   logic [4:0]  rs1p;
   logic [11:0] imm6;

   // Register fields shared by several formats; primed registers map to x8-x15.
   assign c    = ins_in[15:0];
   assign rd   = c[11:7];
   assign rs2  = c[6:2];
   assign rdp  = {2'b01, c[4:2]};
   assign rs1p = {2'b01, c[9:7]};
   assign imm6 = {{6{c[12]}}, c[12], c[6:2]};

   // Expansion table, keyed by quadrant and funct3. FP loads/stores are not
   // part of RV32IC and fall into the illegal default.
   always_comb begin
      ins_out     = ins_in;
      illegal_ins = 1'b0;
      if (is_compressed(ins_in[1:0])) begin
         ins_out = 32'h0;
         unique case ({c[1:0], c[15:13]})
            5'b00_000: begin
               if (c[12:5] == 8'h0) illegal_ins = 1'b1;
               else ins_out = enc_i({2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00},
                                    5'd2, 3'b000, rdp, OP_OP_IMM);
            end
            5'b00_010: ins_out = enc_i({5'b0, c[5], c[12:10], c[6], 2'b00},
                                       rs1p, 3'b010, rdp, OP_LOAD);
            5'b00_110: ins_out = enc_s({5'b0, c[5], c[12:10], c[6], 2'b00},
                                       rdp, rs1p, 3'b010, OP_STORE);
            5'b01_000: ins_out = enc_i(imm6, rd, 3'b000, rd, OP_OP_IMM);
            5'b01_001: ins_out = enc_j({{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7],
                                        c[2], c[11], c[5:3]}, 5'd1);
            5'b01_010: ins_out = enc_i(imm6, 5'd0, 3'b000, rd, OP_OP_IMM);
            5'b01_011: begin
               if ({c[12], c[6:2]} == 6'h0) illegal_ins = 1'b1;
               else if (rd == 5'd2)
                  ins_out = enc_i({{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000},
                                  5'd2, 3'b000, 5'd2, OP_OP_IMM);
               else
                  ins_out = enc_u({{14{c[12]}}, c[12], c[6:2]}, rd, OP_LUI);
            end
            5'b01_100: begin
               case (c[11:10])
                  2'b00: begin
                     if (c[12]) illegal_ins = 1'b1;
                     else ins_out = enc_i({7'b0000000, c[6:2]}, rs1p, 3'b101, rs1p, OP_OP_IMM);
                  end
                  2'b01: begin
                     if (c[12]) illegal_ins = 1'b1;
                     else ins_out = enc_i({7'b0100000, c[6:2]}, rs1p, 3'b101, rs1p, OP_OP_IMM);
                  end
                  2'b10: ins_out = enc_i(imm6, rs1p, 3'b111, rs1p, OP_OP_IMM);
                  2'b11: begin
                     if (c[12]) illegal_ins = 1'b1;
                     else begin
                        case (c[6:5])
                           2'b00: ins_out = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_OP);
                           2'b01: ins_out = enc_r(7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_OP);
                           2'b10: ins_out = enc_r(7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_OP);
                           2'b11: ins_out = enc_r(7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_OP);
                        endcase
                     end
                  end
               endcase
            end
            5'b01_101: ins_out = enc_j({{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7],
                                        c[2], c[11], c[5:3]}, 5'd0);
            5'b01_110,
            5'b01_111: ins_out = enc_b({{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3]},
                                       5'd0, rs1p, {2'b00, c[13]});
            5'b10_000: begin
               if (c[12]) illegal_ins = 1'b1;
               else ins_out = enc_i({7'b0000000, c[6:2]}, rd, 3'b001, rd, OP_OP_IMM);
            end
            5'b10_010: begin
               if (rd == 5'd0) illegal_ins = 1'b1;
               else ins_out = enc_i({4'b0, c[3:2], c[12], c[6:4], 2'b00},
                                    5'd2, 3'b010, rd, OP_LOAD);
            end
            5'b10_100: begin
               if (!c[12]) begin
                  if (rs2 != 5'd0)      ins_out = enc_r(7'b0, rs2, 5'd0, 3'b000, rd, OP_OP);
                  else if (rd != 5'd0)  ins_out = enc_i(12'h0, rd, 3'b000, 5'd0, OP_JALR);
                  else                  illegal_ins = 1'b1;
               end else begin
                  if (rs2 != 5'd0)      ins_out = enc_r(7'b0, rs2, rd, 3'b000, rd, OP_OP);
                  else if (rd != 5'd0)  ins_out = enc_i(12'h0, rd, 3'b000, 5'd1, OP_JALR);
                  else                  ins_out = enc_i(12'h001, 5'd0, 3'b000, 5'd0, OP_SYSTEM);
               end
            end
            5'b10_110: ins_out = enc_s({4'b0, c[8:7], c[12:9], 2'b00},
                                       rs2, 5'd2, 3'b010, OP_STORE);
            default:   illegal_ins = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/fetch_aligner.sv
// -----------------------------------------------------------------------------
// fetch_aligner
// Splits word-aligned 32-bit fetch words into RV32IC instructions, joins
// instructions that straddle a word boundary, expands them through
// comp_decoder and presents them on a registered valid/ready port with PC.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush, flush_pc          redirect request and halfword-aligned target
//   fetch_valid/ready/data   sequential fetch word handshake
//   out_valid/ready          instruction handshake towards decode
//   out_instr, out_pc        expanded instruction and its address
//   out_comp, out_illegal    original was 16 bits / decoder flagged illegal
// -----------------------------------------------------------------------------
module fetch_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_data,
   output logic        fetch_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        out_comp,
   output logic        out_illegal
);
   import fetch_aligner_pkg::*;

   logic [31:0] w_q, w_d;
   logic        w_v_q, w_v_d;
   logic        hp_q, hp_d;
   logic [15:0] c_q, c_d;
   logic        c_v_q, c_v_d;
   logic [31:0] pc_q, pc_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        out_comp_q, out_comp_d;
   logic        out_illegal_q, out_illegal_d;

   logic [15:0] h;
   step_e       step_kind;
   logic [31:0] cand;
   logic [31:0] dec_instr;
   logic        dec_illegal;
   logic        load;
   logic        step;
   logic        emit;
   logic        word_done;
   logic [31:0] step_len;

   comp_decoder u_comp_decoder (
      .ins_in      (cand),
      .ins_out     (dec_instr),
      .illegal_ins (dec_illegal)
   );

   // Decide what the buffered halves allow this cycle, in priority order:
   // finish a pending straddle, emit a 16-bit half, emit a full aligned word,
   // or park an upper-half 32-bit start in the carry register.
   always_comb begin
      h         = hp_q ? w_q[31:16] : w_q[15:0];
      step_kind = STEP_NONE;
      cand      = w_q;
      if (c_v_q && w_v_q) begin
         step_kind = STEP_CARRY_EMIT;
         cand      = {w_q[15:0], c_q};
      end else if (w_v_q && is_compressed(h[1:0])) begin
         step_kind = STEP_HALF;
         cand      = {16'h0, h};
      end else if (w_v_q && !hp_q) begin
         step_kind = STEP_FULL;
      end else if (w_v_q) begin
         step_kind = STEP_CARRY_LOAD;
      end
   end

   // Handshake qualifiers: a step only happens when the output register can
   // take a new value, and the word buffer frees up when its last half goes.
   always_comb begin
      load      = !out_valid_q || out_ready;
      step      = load && (step_kind != STEP_NONE);
      emit      = step && (step_kind != STEP_CARRY_LOAD);
      word_done = step && ((step_kind == STEP_FULL) || (step_kind == STEP_CARRY_LOAD) ||
                           ((step_kind == STEP_HALF) && hp_q));
      step_len  = (step_kind == STEP_HALF) ? 32'd2 : 32'd4;
   end

   assign fetch_ready = !flush && (!w_v_q || word_done);

   // Next-state for buffers, pointer, PC and output register. Flush is
   // applied last so it overrides every other update, including a fetch beat
   // arriving in the same cycle.
   always_comb begin
      w_d           = w_q;
      w_v_d         = w_v_q;
      hp_d          = hp_q;
      c_d           = c_q;
      c_v_d         = c_v_q;
      pc_d          = pc_q;
      out_valid_d   = out_valid_q;
      out_instr_d   = out_instr_q;
      out_pc_d      = out_pc_q;
      out_comp_d    = out_comp_q;
      out_illegal_d = out_illegal_q;

      if (step) begin
         case (step_kind)
            STEP_CARRY_EMIT: begin
               hp_d  = 1'b1;
               c_v_d = 1'b0;
            end
            STEP_HALF:       hp_d = !hp_q;
            STEP_CARRY_LOAD: begin
               c_d   = h;
               c_v_d = 1'b1;
               hp_d  = 1'b0;
            end
            default:         hp_d = hp_q;
         endcase
      end

      if (word_done) w_v_d = 1'b0;
      if (fetch_valid && fetch_ready) begin
         w_d   = fetch_data;
         w_v_d = 1'b1;
      end

      if (emit) begin
         out_valid_d   = 1'b1;
         out_instr_d   = dec_instr;
         out_illegal_d = dec_illegal;
         out_pc_d      = pc_q;
         out_comp_d    = (step_kind == STEP_HALF);
         pc_d          = pc_q + step_len;
      end else if (load) begin
         out_valid_d   = 1'b0;
      end

      if (flush) begin
         w_v_d       = 1'b0;
         c_v_d       = 1'b0;
         out_valid_d = 1'b0;
         pc_d        = flush_pc & 32'hFFFF_FFFE;
         hp_d        = flush_pc[1];
      end
   end

   // State register; reset drops every buffered half immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q           <= 32'h0;
         w_v_q         <= 1'b0;
         hp_q          <= RESET_PC[1];
         c_q           <= 16'h0;
         c_v_q         <= 1'b0;
         pc_q          <= RESET_PC & 32'hFFFF_FFFE;
         out_valid_q   <= 1'b0;
         out_instr_q   <= 32'h0;
         out_pc_q      <= 32'h0;
         out_comp_q    <= 1'b0;
         out_illegal_q <= 1'b0;
      end else begin
         w_q           <= w_d;
         w_v_q         <= w_v_d;
         hp_q          <= hp_d;
         c_q           <= c_d;
         c_v_q         <= c_v_d;
         pc_q          <= pc_d;
         out_valid_q   <= out_valid_d;
         out_instr_q   <= out_instr_d;
         out_pc_q      <= out_pc_d;
         out_comp_q    <= out_comp_d;
         out_illegal_q <= out_illegal_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_instr   = out_instr_q;
   assign out_pc      = out_pc_q;
   assign out_comp    = out_comp_q;
   assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_fetch_aligner.sv
// -----------------------------------------------------------------------------
// tb_fetch_aligner
// Directed bench for fetch_aligner: reset values, aligned words, compressed
// pairs, straddles, backpressure, flush, illegal halfwords, mid-stream reset
// and a back-to-back stream of assorted compressed encodings.
// -----------------------------------------------------------------------------
module tb_fetch_aligner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = 32'h0;
   logic        fetch_valid = 1'b0;
   logic [31:0] fetch_data = 32'h0;
   logic        fetch_ready;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_comp;
   logic        out_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_aligner dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .fetch_valid (fetch_valid),
      .fetch_data  (fetch_data),
      .fetch_ready (fetch_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_comp    (out_comp),
      .out_illegal (out_illegal)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Outputs are packed as {valid, instr, pc, comp, illegal}.
   function automatic logic [66:0] outs();
      return {out_valid, out_instr, out_pc, out_comp, out_illegal};
   endfunction

   function automatic logic [66:0] mk(input logic v, input logic [31:0] i,
                                      input logic [31:0] pc, input logic c, input logic il);
      return {v, i, pc, c, il};
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      flush       = 1'b0;
      fetch_valid = 1'b0;
      out_ready   = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      n_checks++;
      if (outs() !== 67'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got %h expected %h", outs(), 67'h0);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (fetch_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reset_fetch_ready: got %b expected 1", fetch_ready);
      end
   endtask

   task automatic test_plain_word();
      do_reset();
      fetch_valid = 1'b1;
      fetch_data  = 32'h0000_0513;
      #1;
      n_checks++;
      if (fetch_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL plain_ready: got %b expected 1", fetch_ready);
      end
      tick();
      fetch_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL plain_latency: got out_valid=%b expected 0", out_valid);
      end
      tick();
      n_checks++;
      if (outs() !== mk(1'b1, 32'h0000_0513, 32'h0, 1'b0, 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL plain_out: got %h expected %h", outs(),
                  mk(1'b1, 32'h0000_0513, 32'h0, 1'b0, 1'b0));
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL plain_drain: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_two_compressed();
      do_reset();
      fetch_valid = 1'b1;
      fetch_data  = 32'h0505_0505;
      tick();
      fetch_valid = 1'b0;
      #1;
      n_checks++;
      if (fetch_ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL two_hold_ready: got %b expected 0", fetch_ready);
      end
      tick();
      n_checks++;
      if (outs() !== mk(1'b1, 32'h0015_0513, 32'h0, 1'b1, 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL two_first: got %h expected %h", outs(),
                  mk(1'b1, 32'h0015_0513, 32'h0, 1'b1, 1'b0));
      end
      n_checks++;
      if (fetch_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL two_release_ready: got %b expected 1", fetch_ready);
      end
      tick();
      n_checks++;
      if (outs() !== mk(1'b1, 32'h0015_0513, 32'h2, 1'b1, 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL two_second: got %h expected %h", outs(),
                  mk(1'b1, 32'h0015_0513, 32'h2, 1'b1, 1'b0));
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL two_drain: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_straddle();
      do_reset();
      fetch_valid = 1'b1;
      fetch_data  = 32'h0513_0505;
      tick();
      fetch_data  = 32'h0505_0000;
      tick();
      n_checks++;
      if (outs() !== mk(1'b1, 32'h0015_0513, 32'h0, 1'b1, 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL straddle_first: got %h expected %h", outs(),
                  mk(1'b1, 32'h0015_0513, 32'h0, 1'b1, 1'b0));
      end
      n_checks++;
      if (fetch_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL straddle_ready: got %b expected 1", fetch_ready);
      end
      tick();
      fetch_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL straddle_bubble: got out_valid=%b expected 0", out_valid);
      end
      tick();
      n_checks++;
      if (outs() !== mk(1'b1, 32'h0000_0513, 32'h2, 1'b0, 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL straddle_joined: got %h expected %h", outs(),
                  mk(1'b1, 32'h0000_0513, 32'h2, 1'b0, 1'b0));
      end
      tick();
      n_checks++;
      if (outs() !== mk(1'b1, 32'h0015_0513, 32'h6, 1'b1, 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL straddle_tail: got %h expected %h", outs(),
                  mk(1'b1, 32'h0015_0513, 32'h6, 1'b1, 1'b0));
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL straddle_drain: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [66:0] held;
      do_reset();
      fetch_valid = 1'b1;
      fetch_data  = 32'h0505_0505;
      tick();
      fetch_data  = 32'h0000_0513;
      tick();
      held = mk(1'b1, 32'h0015_0513, 32'h0, 1'b1, 1'b0);
      n_checks++;
      if (outs() !== held) begin
         n_fail++;
         $display("[TB] FAIL bp_first: got %h expected %h", outs(), held);
      end
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (outs() !== held) begin
            n_fail++;
            $display("[TB] FAIL bp_hold[%0d]: got %h expected %h", i, outs(), held);
         end
         n_checks++;
         if (fetch_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_ready[%0d]: got %b expected 0", i, fetch_ready);
         end
      end
      out_ready = 1'b1;
      tick();
      fetch_valid = 1'b0;
      n_checks++;
      if (outs() !== mk(1'b1, 32'h0015_0513, 32'h2, 1'b1, 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL bp_release: got %h expected %h", outs(),
                  mk(1'b1, 32'h0015_0513, 32'h2, 1'b1, 1'b0));
      end
      tick();
      n_checks++;
      if (outs() !== mk(1'b1, 32'h0000_0513, 32'h4, 1'b0, 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL bp_next_word: got %h expected %h", outs(),
                  mk(1'b1, 32'h0000_0513, 32'h4, 1'b0, 1'b0));
      end
   endtask

   task automatic test_flush();
      do_reset();
      fetch_valid = 1'b1;
      fetch_data  = 32'h0513_0505;
      tick();
      fetch_valid = 1'b0;
      tick();
      tick();
      // carry now holds the low half of a straddling instruction
      flush       = 1'b1;
      flush_pc    = 32'h0000_0102;
      fetch_valid = 1'b1;
      fetch_data  = 32'h0000_0513;
      #1;
      n_checks++;
      if (fetch_ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL flush_blocks_fetch: got %b expected 0", fetch_ready);
      end
      tick();
      flush       = 1'b0;
      fetch_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL flush_out_invalid: got out_valid=%b expected 0", out_valid);
      end
      fetch_valid = 1'b1;
      fetch_data  = 32'h0505_0000;
      tick();
      fetch_valid = 1'b0;
      tick();
      n_checks++;
      if (outs() !== mk(1'b1, 32'h0015_0513, 32'h102, 1'b1, 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL flush_target: got %h expected %h", outs(),
                  mk(1'b1, 32'h0015_0513, 32'h102, 1'b1, 1'b0));
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL flush_single: got out_valid=%b expected 0", out_valid);
      end
      fetch_valid = 1'b1;
      fetch_data  = 32'h0000_0513;
      tick();
      fetch_valid = 1'b0;
      tick();
      n_checks++;
      if (outs() !== mk(1'b1, 32'h0000_0513, 32'h104, 1'b0, 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL flush_carry_gone: got %h expected %h", outs(),
                  mk(1'b1, 32'h0000_0513, 32'h104, 1'b0, 1'b0));
      end
      flush    = 1'b1;
      flush_pc = 32'h0000_0200;
      tick();
      flush = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL flush_with_ready: got out_valid=%b expected 0", out_valid);
      end
      fetch_valid = 1'b1;
      fetch_data  = 32'h0000_0513;
      tick();
      fetch_valid = 1'b0;
      tick();
      n_checks++;
      if (outs() !== mk(1'b1, 32'h0000_0513, 32'h200, 1'b0, 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL flush_aligned_target: got %h expected %h", outs(),
                  mk(1'b1, 32'h0000_0513, 32'h200, 1'b0, 1'b0));
      end
   endtask

   task automatic test_illegal();
      do_reset();
      fetch_valid = 1'b1;
      fetch_data  = 32'h0505_0000;
      tick();
      fetch_valid = 1'b0;
      tick();
      n_checks++;
      if ({out_valid, out_pc, out_comp, out_illegal} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL illegal_flag: got v=%b pc=%h c=%b il=%b expected v=1 pc=0 c=1 il=1",
                  out_valid, out_pc, out_comp, out_illegal);
      end
      tick();
      n_checks++;
      if (outs() !== mk(1'b1, 32'h0015_0513, 32'h2, 1'b1, 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL illegal_next: got %h expected %h", outs(),
                  mk(1'b1, 32'h0015_0513, 32'h2, 1'b1, 1'b0));
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      fetch_valid = 1'b1;
      fetch_data  = 32'h0505_0505;
      tick();
      fetch_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if (outs() !== 67'h0) begin
         n_fail++;
         $display("[TB] FAIL midreset_async: got %h expected %h", outs(), 67'h0);
      end
      tick();
      rst = 1'b0;
      fetch_valid = 1'b1;
      fetch_data  = 32'h0000_0513;
      tick();
      fetch_valid = 1'b0;
      tick();
      n_checks++;
      if (outs() !== mk(1'b1, 32'h0000_0513, 32'h0, 1'b0, 1'b0)) begin
         n_fail++;
         $display("[TB] FAIL midreset_restart: got %h expected %h", outs(),
                  mk(1'b1, 32'h0000_0513, 32'h0, 1'b0, 1'b0));
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words [4];
      logic [31:0] expd  [8];
      logic        accepted;
      int          wi;
      int          oi;
      int          done_cyc;
      words = '{32'h852E_557D, 32'h8082_4150, 32'hA001_952E, 32'h4522_0028};
      expd  = '{32'hFFF0_0513, 32'h00B0_0533, 32'h0045_2603, 32'h0000_8067,
                32'h00B5_0533, 32'h0000_006F, 32'h0081_0513, 32'h0081_2503};
      do_reset();
      wi       = 0;
      oi       = 0;
      done_cyc = -1;
      for (int cyc = 0; cyc < 40 && oi < 8; cyc++) begin
         fetch_valid = (wi < 4);
         fetch_data  = (wi < 4) ? words[wi] : 32'h0;
         #1;
         accepted = fetch_valid && fetch_ready;
         tick();
         if (accepted) wi++;
         if (out_valid) begin
            n_checks++;
            if (outs() !== mk(1'b1, expd[oi], 32'(oi * 2), 1'b1, 1'b0)) begin
               n_fail++;
               $display("[TB] FAIL b2b_out[%0d]: got %h expected %h", oi, outs(),
                        mk(1'b1, expd[oi], 32'(oi * 2), 1'b1, 1'b0));
            end
            oi++;
            if (oi == 8) done_cyc = cyc;
         end
      end
      fetch_valid = 1'b0;
      n_checks++;
      if (oi !== 8) begin
         n_fail++;
         $display("[TB] FAIL b2b_count: got %0d outputs expected 8", oi);
      end
      n_checks++;
      if (done_cyc !== 8) begin
         n_fail++;
         $display("[TB] FAIL b2b_throughput: last output at cycle %0d expected 8", done_cyc);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_plain_word();
      test_two_compressed();
      test_straddle();
      test_backpressure();
      test_flush();
      test_illegal();
      test_reset_midstream();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
